// File: rtl/bram_capture_ctrl.sv
// Decimating capture controller: packs N_CH samples per BRAM word and fills the
// buffer either once (linear) or as a ring around a trigger with pre-trigger depth.
module bram_capture_ctrl #(
  parameter int DATA_W = 14,
  parameter int N_CH   = 2,
  parameter int ADDR_W = 11,
  parameter int DIV_W  = 22
) (
  input  logic                     pdh_clk,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [DIV_W-1:0]         divcode_i,
  input  logic                     mode_i,
  input  logic [ADDR_W-1:0]        pretrig_i,
  input  logic                     trig_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic                     ack_i,
  output logic                     bram_we_o,
  output logic [ADDR_W-1:0]        bram_addr_o,
  output logic [N_CH*DATA_W-1:0]   bram_din_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        trig_addr_o
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH   = CNT_ONE << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SINGLE,
    S_ARM,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic [ADDR_W-1:0] pretrig_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   arm_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic              trig_q;
  logic              trig_pend;

  logic              run;
  logic              strobe;
  logic              trig_rise;
  logic [ADDR_W:0]   post_len;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    run       = (state == S_SINGLE) || (state == S_ARM) ||
                (state == S_WAIT_TRIG) || (state == S_POST);
    strobe    = run && enable_i && (cnt == div_q);
    trig_rise = trig_i & ~trig_q;
    post_len  = DEPTH - {1'b0, pretrig_q};
  end

  // NOTE: all state updates are non-blocking so every branch sees pre-edge values.
  always_ff @(posedge pdh_clk) begin
    if (rst_i) begin
      state       <= S_IDLE;
      div_q       <= '0;
      pretrig_q   <= '0;
      cnt         <= '0;
      wptr        <= '0;
      arm_cnt     <= '0;
      post_cnt    <= '0;
      trig_q      <= 1'b0;
      trig_pend   <= 1'b0;
      bram_we_o   <= 1'b0;
      bram_addr_o <= '0;
      bram_din_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      trig_addr_o <= '0;
    end else begin
      trig_q    <= trig_i;
      bram_we_o <= 1'b0;

      if (!enable_i) begin
        // Abort wins over ack and trigger; a write already on the port still completes.
        state     <= S_IDLE;
        cnt       <= '0;
        wptr      <= '0;
        arm_cnt   <= '0;
        trig_pend <= 1'b0;
        busy_o    <= 1'b0;
        done_o    <= 1'b0;
      end else begin
        if (run) cnt <= strobe ? '0 : cnt + 1'b1;

        if (strobe) begin
          bram_we_o   <= 1'b1;
          bram_din_o  <= data_i;
          bram_addr_o <= wptr;
          wptr        <= wptr + 1'b1;
        end

        case (state)
          S_IDLE: begin
            div_q       <= divcode_i;
            pretrig_q   <= pretrig_i;
            cnt         <= '0;
            wptr        <= '0;
            arm_cnt     <= '0;
            trig_pend   <= 1'b0;
            trig_addr_o <= '0;
            busy_o      <= 1'b1;
            if (!mode_i)               state <= S_SINGLE;
            else if (pretrig_i == '0)  state <= S_WAIT_TRIG;
            else                       state <= S_ARM;
          end

          S_SINGLE: begin
            if (strobe && (&wptr)) begin
              state  <= S_DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end

          S_ARM: begin
            // Triggers are deliberately not latched until the pre-trigger history is full.
            if (strobe) begin
              arm_cnt <= arm_cnt + 1'b1;
              if (arm_cnt + 1'b1 == {1'b0, pretrig_q}) state <= S_WAIT_TRIG;
            end
          end

          S_WAIT_TRIG: begin
            if (strobe && (trig_pend || trig_rise)) begin
              trig_addr_o <= wptr;
              trig_pend   <= 1'b0;
              if (post_len == CNT_ONE) begin
                state  <= S_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                post_cnt <= post_len - CNT_ONE;
                state    <= S_POST;
              end
            end else if (trig_rise) begin
              trig_pend <= 1'b1;
            end
          end

          S_POST: begin
            if (strobe) begin
              if (post_cnt == CNT_ONE) begin
                state  <= S_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                post_cnt <= post_cnt - CNT_ONE;
              end
            end
          end

          S_DONE: begin
            if (ack_i) begin
              state  <= S_IDLE;
              done_o <= 1'b0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Self-checking bench for bram_capture_ctrl: expected BRAM writes are queued as
// each capture is started and matched against the write port by a monitor.
module tb_bram_capture_ctrl;

  localparam int DATA_W = 14;
  localparam int N_CH   = 2;
  localparam int ADDR_W = 4;
  localparam int DIV_W  = 22;
  localparam int WORD_W = N_CH * DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
    logic              last;
  } wr_t;

  logic              pdh_clk = 1'b0;
  logic              rst_i;
  logic              enable_i;
  logic [DIV_W-1:0]  divcode_i;
  logic              mode_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic              trig_i;
  logic [WORD_W-1:0] data_i;
  logic              ack_i;
  logic              bram_we_o;
  logic [ADDR_W-1:0] bram_addr_o;
  logic [WORD_W-1:0] bram_din_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_addr_o;

  wr_t sb[$];
  wr_t exp_w;
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;

  bram_capture_ctrl #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W),
    .DIV_W  (DIV_W)
  ) dut (
    .pdh_clk     (pdh_clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .divcode_i   (divcode_i),
    .mode_i      (mode_i),
    .pretrig_i   (pretrig_i),
    .trig_i      (trig_i),
    .data_i      (data_i),
    .ack_i       (ack_i),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_din_o  (bram_din_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .trig_addr_o (trig_addr_o)
  );

  always #5 pdh_clk = ~pdh_clk;

  // Ramp value presented during clock cycle k; channel 1 is offset so lanes differ.
  function automatic logic [WORD_W-1:0] ramp_word(input int k);
    logic [DATA_W-1:0] s;
    s = DATA_W'(k);
    return {s + DATA_W'(100), s};
  endfunction

  task automatic tick();
    @(posedge pdh_clk);
    #1;
    cyc++;
    data_i = ramp_word(cyc);
  endtask

  // Every capture starts at address 0; sample i is taken in cycle first + step*i.
  task automatic push_writes(input int first, input int step, input int n, input bit ends_done);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = ADDR_W'(i);
      w.din  = ramp_word(first + step * i);
      w.last = ends_done && (i == n - 1);
      sb.push_back(w);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  always @(negedge pdh_clk) begin
    if (bram_we_o === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%0d din=%h, no write expected", bram_addr_o, bram_din_o);
      end else begin
        exp_w = sb.pop_front();
        if ({bram_addr_o, bram_din_o, done_o} !== {exp_w.addr, exp_w.din, exp_w.last}) begin
          n_err++;
          $display("FAIL write_check: got addr=%0d din=%h done=%b, want addr=%0d din=%h done=%b",
                   bram_addr_o, bram_din_o, done_o, exp_w.addr, exp_w.din, exp_w.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst_i     = 1'b1;
    enable_i  = 1'b1;
    mode_i    = 1'b0;
    divcode_i = '0;
    pretrig_i = '0;
    trig_i    = 1'b0;
    ack_i     = 1'b0;
    data_i    = ramp_word(0);
    repeat (2) begin
      tick();
      n_vec++;
      if ({bram_we_o, bram_addr_o, bram_din_o, busy_o, done_o, trig_addr_o} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: we=%b addr=%0d din=%h busy=%b done=%b taddr=%0d, want all 0",
                 bram_we_o, bram_addr_o, bram_din_o, busy_o, done_o, trig_addr_o);
      end
    end
    rst_i    = 1'b0;
    enable_i = 1'b0;
    tick();
    n_vec++;
    if ({bram_we_o, busy_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: we=%b busy=%b done=%b, want 000", bram_we_o, busy_o, done_o);
    end
  endtask

  task automatic test_single_shot();
    bit ok;
    mode_i    = 1'b0;
    divcode_i = 22'd3;
    pretrig_i = 4'd7;
    push_writes(cyc + 4, 4, 16, 1'b1);
    enable_i = 1'b1;
    tick();
    // Later input changes must not disturb the latched configuration.
    divcode_i = '0;
    mode_i    = 1'b1;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: busy=%b, want 1", busy_o);
    end
    wait_done(100, ok);
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL single_done_timeout: done=%b, want 1 within 100 clk", done_o);
    end
    n_vec++;
    if ({busy_o, trig_addr_o} !== {1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL single_status: busy=%b taddr=%0d, want busy=0 taddr=0", busy_o, trig_addr_o);
    end
    repeat (6) tick();
    n_vec++;
    if (sb.size() != 0 || done_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_hold: pending=%0d done=%b, want pending=0 done=1", sb.size(), done_o);
    end
    sb.delete();
    ack_i = 1'b1;
    tick();
    ack_i    = 1'b0;
    enable_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_ack: done=%b, want 0", done_o);
    end
    repeat (3) tick();
  endtask

  task automatic run_ring(input string name, input int budget, input logic [ADDR_W-1:0] want_taddr);
    bit ok;
    wait_done(budget, ok);
    n_vec++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done_timeout: done=%b, want 1 within %0d clk", name, done_o, budget);
    end
    n_vec++;
    if ({busy_o, trig_addr_o} !== {1'b0, want_taddr}) begin
      n_err++;
      $display("FAIL %s_trig_addr: busy=%b taddr=%0d, want busy=0 taddr=%0d", name, busy_o, trig_addr_o, want_taddr);
    end
    repeat (4) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d writes missing, want 0", name, sb.size());
    end
    sb.delete();
    ack_i    = 1'b1;
    enable_i = 1'b0;
    tick();
    ack_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_release: done=%b, want 0", name, done_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_ring_trigger();
    mode_i    = 1'b1;
    divcode_i = '0;
    pretrig_i = 4'd5;
    push_writes(cyc + 1, 1, 31, 1'b1);
    enable_i = 1'b1;
    repeat (21) tick();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    run_ring("ring", 60, 4'd4);
  endtask

  task automatic test_arm_ignore();
    mode_i    = 1'b1;
    divcode_i = '0;
    pretrig_i = 4'd5;
    push_writes(cyc + 1, 1, 20, 1'b1);
    enable_i = 1'b1;
    repeat (3) tick();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    repeat (6) tick();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    run_ring("arm_ignore", 60, 4'd9);
  endtask

  task automatic test_pending_trigger();
    mode_i    = 1'b1;
    divcode_i = 22'd3;
    pretrig_i = 4'd2;
    push_writes(cyc + 4, 4, 18, 1'b1);
    enable_i = 1'b1;
    repeat (18) tick();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    run_ring("pending", 100, 4'd4);
  endtask

  task automatic test_abort_restart();
    bit ok;
    mode_i    = 1'b1;
    divcode_i = '0;
    pretrig_i = 4'd3;
    push_writes(cyc + 1, 1, 10, 1'b0);
    enable_i = 1'b1;
    repeat (7) tick();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL abort_busy_before: busy=%b, want 1", busy_o);
    end
    enable_i = 1'b0;
    tick();
    n_vec++;
    if ({bram_we_o, busy_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_state: we=%b busy=%b done=%b, want 000", bram_we_o, busy_o, done_o);
    end
    repeat (5) tick();
    n_vec++;
    if (sb.size() != 0 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drain: pending=%0d done=%b, want pending=0 done=0", sb.size(), done_o);
    end
    sb.delete();

    mode_i    = 1'b0;
    divcode_i = '0;
    push_writes(cyc + 1, 1, 16, 1'b1);
    enable_i = 1'b1;
    wait_done(40, ok);
    n_vec++;
    if (ok !== 1'b1 || trig_addr_o !== 4'd0) begin
      n_err++;
      $display("FAIL restart_done: done_seen=%b taddr=%0d, want 1 and 0", ok, trig_addr_o);
    end
    repeat (4) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL restart_drain: %0d writes missing, want 0", sb.size());
    end
    sb.delete();
    enable_i = 1'b0;
    tick();
    n_vec++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL restart_release: done=%b, want 0", done_o);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_ring_trigger();
    test_arm_ignore();
    test_pending_trigger();
    test_abort_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
